// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame constants
// for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte write port
// into the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous circular FIFO,
// pointers one bit wider than the address.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // A full FIFO refuses pushes even when popping.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed 8N1 serialiser,
// LSB first, registered txd.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  uart_tx_if.slave                      wr,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] rdata;
  logic                 baud_last;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr.wr_valid),
    .wdata  (wr.wr_data),
    .pop    (pop),
    .rdata  (rdata),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign wr.wr_ready = !full;
  assign baud_last   = (baud_q == LAST);
  assign busy        = (state_q != IDLE) || !empty;
  assign txd         = txd_q;

  // Next state, baud count, shift and pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + CW'(1);
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rdata;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == DLAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (idx_q != SLAST) begin
            idx_d = idx_q + 3'd1;
          end else if (!empty) begin
            pop     = 1'b1;
            shift_d = rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the coming cycle.
  always_comb begin
    txd_d = 1'b1;
    unique case (1'b1)
      (state_d == START): txd_d = 1'b0;
      (state_d == DATA):  txd_d = shift_d[0];
      default:            txd_d = 1'b1;
    endcase
  end

  // State, counters and line flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table vectors plus frame
// scoreboard for uart_tx at 4 clocks/bit.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FD  = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       txd;
  logic       busy;
  logic [3:0] fifo_count;

  uart_tx_if wr_if ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (wr_if),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] sb [$];
  int         start_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic [3:0] cnt_acc;
    logic [3:0] cnt_pop;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a byte; returns just after the
  // accepting edge.
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    while (!wr_if.wr_ready && t < 200) begin
      step(1);
      t++;
    end
    if (!wr_if.wr_ready) begin
      check("send_timeout", 32'(wr_if.wr_ready), 1);
    end else begin
      sb.push_back({1'b1, d, 1'b0});
      step(1);
    end
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    while (busy && t < max) begin
      step(1);
      t++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_cyc(input int target);
    int t;
    t = 0;
    while (cyc < target && t < 500) begin
      step(1);
      t++;
    end
    check("wait_cyc", cyc, target);
  endtask

  // Line monitor: compares every frame cycle
  // against the queued expected frame.
  initial begin
    bit         active;
    bit         unexp;
    int         mc;
    int         bad;
    int         idx;
    logic [9:0] cur;
    logic [9:0] cap;
    active = 0;
    unexp  = 0;
    mc     = 0;
    bad    = 0;
    cur    = '0;
    cap    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        active = 0;
      end else begin
        if (!active && txd === 1'b0) begin
          active = 1;
          mc     = 0;
          bad    = 0;
          cap    = '0;
          start_q.push_back(cyc);
          if (sb.size() == 0) begin
            unexp = 1;
            cur   = '0;
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame at %0d",
                     cyc);
          end else begin
            unexp = 0;
            cur   = sb.pop_front();
          end
        end else if (active) begin
          mc++;
        end
        if (active) begin
          idx = mc / CPB;
          if (txd !== cur[idx]) bad++;
          if (mc % CPB == CPB / 2) cap[idx] = txd;
          if (mc == 10 * CPB - 1) begin
            active = 0;
            if (!unexp) begin
              n_vec++;
              if (bad != 0 || cap !== cur) begin
                n_err++;
                $display(
                  "FAIL frame: got %b want %b (%0d bad cycles)",
                  cap, cur, bad);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int hb;
    int t0;
    int s;
    int acc9;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;

    tbl[0] = '{8'h55, 10'b1010101010, 4'd1, 4'd0};
    tbl[1] = '{8'h80, 10'b1100000000, 4'd1, 4'd0};
    tbl[2] = '{8'h01, 10'b1000000010, 4'd1, 4'd0};
    tbl[3] = '{8'hFF, 10'b1111111110, 4'd1, 4'd0};
    tbl[4] = '{8'h3C, 10'b1001111000, 4'd1, 4'd0};

    // Reset state.
    step(3);
    check("rst_txd", 32'(txd), 1);
    check("rst_ready", 32'(wr_if.wr_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(fifo_count), 0);
    resetn = 1'b1;

    hb = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (txd !== 1'b1 || busy !== 1'b0 ||
          wr_if.wr_ready !== 1'b1 ||
          fifo_count !== 4'd0) hb++;
    end
    check("idle50", hb, 0);

    // Single frames from the table.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data);
      check("frame_model", 32'(sb[$]),
            32'(tbl[i].frame));
      check("cnt_acc", 32'(fifo_count),
            32'(tbl[i].cnt_acc));
      check("busy_acc", 32'(busy), 1);
      t0 = cyc;
      step(1);
      check("start_low", 32'(txd), 0);
      check("cnt_pop", 32'(fifo_count),
            32'(tbl[i].cnt_pop));
      wait_idle(200);
      check("busy_len", cyc - t0, 41);
      hb = 0;
      for (int k = 0; k < 6; k++) begin
        step(1);
        if (txd !== 1'b1) hb++;
      end
      check("idle_gap", hb, 0);
    end

    // Ten bytes with valid held high.
    start_q.delete();
    acc9 = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
      if (i == 7)
        check("ready_8th", 32'(wr_if.wr_ready), 1);
      if (i == 8)
        check("ready_9th", 32'(wr_if.wr_ready), 0);
      if (i == 9) acc9 = cyc;
    end
    if (start_q.size() > 0)
      check("acc10_time", acc9 - start_q[0], 41);
    else
      check("acc10_start", start_q.size(), 1);
    wait_idle(1000);
    check("b2b_frames", start_q.size(), 10);
    hb = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 10 * CPB)
        hb++;
    check("b2b_contig", hb, 0);
    step(5);

    // Push on the STOP->START pop cycle.
    start_q.delete();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check("cnt3", 32'(fifo_count), 3);
    s = (start_q.size() > 0) ? start_q[0] : cyc;
    wait_cyc(s + 39);
    check("cnt3_pre", 32'(fifo_count), 3);
    send(8'h5A);
    check("cnt3_post", 32'(fifo_count), 3);
    wait_idle(1000);
    check("pp_frames", start_q.size(), 5);
    step(5);

    // Reset during data bit 3.
    start_q.delete();
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    s = (start_q.size() > 0) ? start_q[0] : cyc;
    wait_cyc(s + 17);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd), 1);
    check("mid_rst_cnt", 32'(fifo_count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    sb.delete();
    step(3);
    resetn = 1'b1;
    hb = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (txd !== 1'b1 || busy !== 1'b0) hb++;
    end
    check("post_rst_idle", hb, 0);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
